tile_map_arbiter: RTL and testbench

TILE_MAP_ARBITER -- requirements
Module: tile_map_arbiter

---
 rtl/tile_map_arbiter.sv | 154 +++++++++++++++
 tb/tb_tile_map_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_map_arbiter.sv
// Tile-map RAM arbiter: render port has priority, query/write ports share round-robin,
// with starvation stealing. Define TILE_MAP_ARBITER_STATS_EN to add grant statistics outputs.
module tile_map_arbiter #(
    parameter int NTILES     = 300,
    parameter int STARVE_MAX = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       r_req,
    input  logic [8:0] r_addr,
    output logic [3:0] r_rdata,
    output logic       r_valid,
    output logic       r_miss,
    input  logic       q_req,
    input  logic [8:0] q_addr,
    output logic       q_gnt,
    output logic [3:0] q_rdata,
    output logic       q_valid,
    input  logic       w_req,
    input  logic [8:0] w_addr,
    input  logic [3:0] w_data,
    output logic       w_gnt,
    output logic       mem_en,
    output logic       mem_we,
    output logic [8:0] mem_addr,
    output logic [3:0] mem_wdata,
    input  logic [3:0] mem_rdata,
    output logic       addr_err
`ifdef TILE_MAP_ARBITER_STATS_EN
    ,
    output logic [15:0] stat_q,
    output logic [15:0] stat_w,
    output logic [15:0] stat_steal
`endif
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    typedef enum logic {RR_Q = 1'b0, RR_W = 1'b1} rr_t;

    rr_t           rr;
    logic [CW-1:0] q_wait;
    logic [CW-1:0] w_wait;
    logic          q_starved;
    logic          w_starved;
    logic          gnt_r;
    logic          gnt_q;
    logic          gnt_w;
    logic          steal;
    logic          any_gnt;
    logic          oor;
    logic [8:0]    sel_addr;
    logic          r_pend;
    logic          q_pend;
    logic          r_zero;
    logic          q_zero;

    assign q_starved = q_req && (q_wait == CW'(STARVE_MAX));
    assign w_starved = w_req && (w_wait == CW'(STARVE_MAX));

    // A starved Q/W port takes the render slot; otherwise render always wins.
    always_comb begin
        gnt_r = 1'b0;
        gnt_q = 1'b0;
        gnt_w = 1'b0;
        steal = 1'b0;
        if (!reset) begin
            if (r_req && (q_starved || w_starved)) begin
                steal = 1'b1;
                if (q_starved && w_starved) begin
                    if (rr == RR_Q) gnt_q = 1'b1;
                    else            gnt_w = 1'b1;
                end else if (q_starved) begin
                    gnt_q = 1'b1;
                end else begin
                    gnt_w = 1'b1;
                end
            end else if (r_req) begin
                gnt_r = 1'b1;
            end else if (q_req && w_req) begin
                if (rr == RR_Q) gnt_q = 1'b1;
                else            gnt_w = 1'b1;
            end else if (q_req) begin
                gnt_q = 1'b1;
            end else if (w_req) begin
                gnt_w = 1'b1;
            end
        end
    end

    always_comb begin
        sel_addr = 9'd0;
        if (gnt_r)      sel_addr = r_addr;
        else if (gnt_q) sel_addr = q_addr;
        else if (gnt_w) sel_addr = w_addr;
    end

    assign any_gnt   = gnt_r || gnt_q || gnt_w;
    assign oor       = any_gnt && (32'(sel_addr) >= NTILES);
    assign addr_err  = oor;
    assign mem_en    = any_gnt && !oor;
    assign mem_we    = gnt_w && !oor;
    assign mem_addr  = sel_addr;
    assign mem_wdata = gnt_w ? w_data : 4'h0;
    assign q_gnt     = gnt_q;
    assign w_gnt     = gnt_w;

    // Out-of-range reads still respond, but with zero data instead of the RAM output.
    assign r_valid = r_pend;
    assign q_valid = q_pend;
    assign r_rdata = (r_pend && !r_zero) ? mem_rdata : 4'h0;
    assign q_rdata = (q_pend && !q_zero) ? mem_rdata : 4'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend <= 1'b0;
            q_pend <= 1'b0;
            r_zero <= 1'b0;
            q_zero <= 1'b0;
            r_miss <= 1'b0;
            rr     <= RR_Q;
            q_wait <= '0;
            w_wait <= '0;
        end else begin
            r_pend <= gnt_r;
            q_pend <= gnt_q;
            r_zero <= gnt_r && oor;
            q_zero <= gnt_q && oor;
            r_miss <= steal;
            if (gnt_q)      rr <= RR_W;
            else if (gnt_w) rr <= RR_Q;
            if (!q_req || gnt_q)               q_wait <= '0;
            else if (q_wait != CW'(STARVE_MAX)) q_wait <= q_wait + 1'b1;
            if (!w_req || gnt_w)               w_wait <= '0;
            else if (w_wait != CW'(STARVE_MAX)) w_wait <= w_wait + 1'b1;
        end
    end

`ifdef TILE_MAP_ARBITER_STATS_EN
    // Saturating grant statistics.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_q     <= 16'd0;
            stat_w     <= 16'd0;
            stat_steal <= 16'd0;
        end else begin
            if (gnt_q && stat_q != 16'hFFFF)         stat_q     <= stat_q + 16'd1;
            if (gnt_w && stat_w != 16'hFFFF)         stat_w     <= stat_w + 16'd1;
            if (steal && stat_steal != 16'hFFFF)     stat_steal <= stat_steal + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tile_map_arbiter.sv
// Directed self-checking bench for tile_map_arbiter with a behavioural 1-cycle-latency RAM.
module tb_tile_map_arbiter;

    logic       clk;
    logic       reset;
    logic       r_req;
    logic [8:0] r_addr;
    logic [3:0] r_rdata;
    logic       r_valid;
    logic       r_miss;
    logic       q_req;
    logic [8:0] q_addr;
    logic       q_gnt;
    logic [3:0] q_rdata;
    logic       q_valid;
    logic       w_req;
    logic [8:0] w_addr;
    logic [3:0] w_data;
    logic       w_gnt;
    logic       mem_en;
    logic       mem_we;
    logic [8:0] mem_addr;
    logic [3:0] mem_wdata;
    logic [3:0] mem_rdata;
    logic       addr_err;
`ifdef TILE_MAP_ARBITER_STATS_EN
    logic [15:0] stat_q;
    logic [15:0] stat_w;
    logic [15:0] stat_steal;
`endif

    int checks = 0;
    int errors = 0;

    logic [3:0] ram [512];

    tile_map_arbiter #(.NTILES(300), .STARVE_MAX(64)) dut (
        .clk(clk), .reset(reset),
        .r_req(r_req), .r_addr(r_addr), .r_rdata(r_rdata), .r_valid(r_valid), .r_miss(r_miss),
        .q_req(q_req), .q_addr(q_addr), .q_gnt(q_gnt), .q_rdata(q_rdata), .q_valid(q_valid),
        .w_req(w_req), .w_addr(w_addr), .w_data(w_data), .w_gnt(w_gnt),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .addr_err(addr_err)
`ifdef TILE_MAP_ARBITER_STATS_EN
        , .stat_q(stat_q), .stat_w(stat_w), .stat_steal(stat_steal)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM; output register keeps its last value when idle.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        r_req = 1'b0; r_addr = 9'd0;
        q_req = 1'b0; q_addr = 9'd0;
        w_req = 1'b0; w_addr = 9'd0; w_data = 4'h0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        r_req = 1'b1; r_addr = 9'd5;
        q_req = 1'b1; q_addr = 9'd6;
        reset = 1'b1;
        step();
        step();
        checks++; if (q_gnt !== 1'b0) begin errors++; $display("[TB] FAIL reset_q_gnt: got %0b expected 0", q_gnt); end
        checks++; if (w_gnt !== 1'b0) begin errors++; $display("[TB] FAIL reset_w_gnt: got %0b expected 0", w_gnt); end
        checks++; if (mem_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_en: got %0b expected 0", mem_en); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_we: got %0b expected 0", mem_we); end
        checks++; if (r_valid !== 1'b0 || q_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got r=%0b q=%0b expected 0 0", r_valid, q_valid); end
        checks++; if (r_miss !== 1'b0 || addr_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_miss_err: got miss=%0b err=%0b expected 0 0", r_miss, addr_err); end
        checks++; if (r_rdata !== 4'h0 || q_rdata !== 4'h0) begin errors++; $display("[TB] FAIL reset_rdata: got r=%h q=%h expected 0 0", r_rdata, q_rdata); end
        idle_inputs();
        reset = 1'b0;
        step();
    endtask

    task automatic test_render_priority();
        r_req = 1'b1; r_addr = 9'd5;
        q_req = 1'b1; q_addr = 9'd7;
        #1;
        checks++; if (mem_addr !== 9'd5 || mem_en !== 1'b1) begin errors++; $display("[TB] FAIL prio_mem: got addr=%0d en=%0b expected 5 1", mem_addr, mem_en); end
        checks++; if (q_gnt !== 1'b0) begin errors++; $display("[TB] FAIL prio_q_gnt: got %0b expected 0", q_gnt); end
        step();
        r_req = 1'b0;
        #1;
        checks++; if (r_valid !== 1'b1 || r_rdata !== 4'h8) begin errors++; $display("[TB] FAIL prio_r_resp: got v=%0b d=%h expected 1 8", r_valid, r_rdata); end
        checks++; if (q_gnt !== 1'b1 || mem_addr !== 9'd7) begin errors++; $display("[TB] FAIL prio_q_follow: got gnt=%0b addr=%0d expected 1 7", q_gnt, mem_addr); end
        step();
        q_req = 1'b0;
        #1;
        checks++; if (q_valid !== 1'b1 || q_rdata !== 4'hA) begin errors++; $display("[TB] FAIL prio_q_resp: got v=%0b d=%h expected 1 a", q_valid, q_rdata); end
        checks++; if (r_valid !== 1'b0) begin errors++; $display("[TB] FAIL prio_r_pulse: got %0b expected 0", r_valid); end
        step();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_qg;
        logic [3:0] exp_qv;
        exp_qg = 4'b0101;
        exp_qv = 4'b1010;
        idle_inputs();
        q_req = 1'b1; q_addr = 9'd2;
        w_req = 1'b1; w_addr = 9'd200; w_data = 4'h3;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (q_gnt !== exp_qg[c] || w_gnt !== !exp_qg[c]) begin
                errors++;
                $display("[TB] FAIL rr_gnt[%0d]: got q=%0b w=%0b expected q=%0b w=%0b", c, q_gnt, w_gnt, exp_qg[c], !exp_qg[c]);
            end
            checks++;
            if (q_valid !== exp_qv[c] || (exp_qv[c] && q_rdata !== 4'h5)) begin
                errors++;
                $display("[TB] FAIL rr_qvalid[%0d]: got v=%0b d=%h expected v=%0b d=5", c, q_valid, q_rdata, exp_qv[c]);
            end
            step();
        end
        idle_inputs();
        step();
    endtask

    task automatic test_starvation();
        idle_inputs();
        do_reset();
        r_req = 1'b1; r_addr = 9'd1;
        q_req = 1'b1; q_addr = 9'd3;
        #1;
        for (int run = 0; run < 2; run++) begin
            for (int k = 0; k <= 64; k++) begin
                checks++;
                if (q_gnt !== (k == 64)) begin
                    errors++;
                    $display("[TB] FAIL starve_gnt run%0d k%0d: got %0b expected %0b", run, k, q_gnt, (k == 64));
                end
                if (run == 1 && k == 0) begin
                    checks++;
                    if (r_miss !== 1'b1 || r_valid !== 1'b0) begin errors++; $display("[TB] FAIL starve_miss: got miss=%0b rv=%0b expected 1 0", r_miss, r_valid); end
                    checks++;
                    if (q_valid !== 1'b1 || q_rdata !== 4'h6) begin errors++; $display("[TB] FAIL starve_qresp: got v=%0b d=%h expected 1 6", q_valid, q_rdata); end
                end else if (k >= 1) begin
                    checks++;
                    if (r_valid !== 1'b1 || r_rdata !== 4'h4 || r_miss !== 1'b0) begin
                        errors++;
                        $display("[TB] FAIL starve_render run%0d k%0d: got v=%0b d=%h miss=%0b expected 1 4 0", run, k, r_valid, r_rdata, r_miss);
                    end
                end
                if (k == 64) begin
                    checks++;
                    if (mem_addr !== 9'd3) begin errors++; $display("[TB] FAIL starve_addr: got %0d expected 3", mem_addr); end
                end
                step();
            end
        end
        idle_inputs();
        #1;
        checks++; if (r_miss !== 1'b1) begin errors++; $display("[TB] FAIL starve_miss2: got %0b expected 1", r_miss); end
        step();
        checks++; if (r_miss !== 1'b0) begin errors++; $display("[TB] FAIL starve_miss_pulse: got %0b expected 0", r_miss); end
    endtask

    task automatic test_write_read();
        idle_inputs();
        w_req = 1'b1; w_addr = 9'd120; w_data = 4'hA;
        #1;
        checks++;
        if (w_gnt !== 1'b1 || mem_we !== 1'b1 || mem_en !== 1'b1 || mem_addr !== 9'd120 || mem_wdata !== 4'hA) begin
            errors++;
            $display("[TB] FAIL wr_drive: got gnt=%0b we=%0b en=%0b addr=%0d d=%h expected 1 1 1 120 a", w_gnt, mem_we, mem_en, mem_addr, mem_wdata);
        end
        step();
        idle_inputs();
        q_req = 1'b1; q_addr = 9'd120;
        #1;
        checks++; if (q_gnt !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("[TB] FAIL rd_gnt: got gnt=%0b we=%0b expected 1 0", q_gnt, mem_we); end
        step();
        idle_inputs();
        #1;
        checks++; if (q_valid !== 1'b1 || q_rdata !== 4'hA) begin errors++; $display("[TB] FAIL wr_rd_data: got v=%0b d=%h expected 1 a", q_valid, q_rdata); end
        step();
    endtask

    task automatic test_out_of_range();
        idle_inputs();
        q_req = 1'b1; q_addr = 9'd300;
        #1;
        checks++;
        if (q_gnt !== 1'b1 || addr_err !== 1'b1 || mem_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL oor_q: got gnt=%0b err=%0b en=%0b expected 1 1 0", q_gnt, addr_err, mem_en);
        end
        step();
        idle_inputs();
        w_req = 1'b1; w_addr = 9'd511; w_data = 4'hF;
        #1;
        checks++; if (q_valid !== 1'b1 || q_rdata !== 4'h0) begin errors++; $display("[TB] FAIL oor_q_resp: got v=%0b d=%h expected 1 0", q_valid, q_rdata); end
        checks++;
        if (w_gnt !== 1'b1 || addr_err !== 1'b1 || mem_en !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("[TB] FAIL oor_w: got gnt=%0b err=%0b en=%0b we=%0b expected 1 1 0 0", w_gnt, addr_err, mem_en, mem_we);
        end
        step();
        idle_inputs();
        r_req = 1'b1; r_addr = 9'd299;
        #1;
        checks++; if (addr_err !== 1'b0 || mem_en !== 1'b1) begin errors++; $display("[TB] FAIL edge_299: got err=%0b en=%0b expected 0 1", addr_err, mem_en); end
        step();
        r_addr = 9'd400;
        #1;
        checks++; if (addr_err !== 1'b1 || mem_en !== 1'b0) begin errors++; $display("[TB] FAIL oor_r: got err=%0b en=%0b expected 1 0", addr_err, mem_en); end
        step();
        idle_inputs();
        #1;
        checks++; if (r_valid !== 1'b1 || r_rdata !== 4'h0 || addr_err !== 1'b0) begin errors++; $display("[TB] FAIL oor_r_resp: got v=%0b d=%h err=%0b expected 1 0 0", r_valid, r_rdata, addr_err); end
        step();
    endtask

    task automatic test_reset_cancel();
        idle_inputs();
        q_req = 1'b1; q_addr = 9'd7;
        #1;
        checks++; if (q_gnt !== 1'b1) begin errors++; $display("[TB] FAIL cancel_pre: got %0b expected 1", q_gnt); end
        reset = 1'b1;
        #1;
        checks++; if (q_gnt !== 1'b0) begin errors++; $display("[TB] FAIL cancel_gnt: got %0b expected 0", q_gnt); end
        step();
        reset = 1'b0;
        idle_inputs();
        #1;
        checks++; if (q_valid !== 1'b0) begin errors++; $display("[TB] FAIL cancel_valid: got %0b expected 0", q_valid); end
        step();
    endtask

`ifdef TILE_MAP_ARBITER_STATS_EN
    task automatic test_stats();
        idle_inputs();
        do_reset();
        q_req = 1'b1; q_addr = 9'd0;
        for (int i = 0; i < 10; i++) step();
        idle_inputs();
        step();
        checks++; if (stat_q !== 16'd10) begin errors++; $display("[TB] FAIL stat_q: got %0d expected 10", stat_q); end
        checks++; if (stat_w !== 16'd0 || stat_steal !== 16'd0) begin errors++; $display("[TB] FAIL stat_other: got w=%0d s=%0d expected 0 0", stat_w, stat_steal); end
    endtask
`endif

    initial begin
        for (int i = 0; i < 512; i++) ram[i] = 4'(i + 3);
        mem_rdata = 4'h0;
        idle_inputs();
        reset = 1'b1;
        step();
        test_reset();
        test_render_priority();
        test_round_robin();
        test_starvation();
        test_write_read();
        test_out_of_range();
        test_reset_cancel();
`ifdef TILE_MAP_ARBITER_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
